// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes and control FSM encoding.
package ex_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_t;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: SIZE steps after start, low SIZE bits of the unsigned product.
// done is high during the cycle whose clock edge performs the final step.
module ex_mul_iter #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            done,
  output logic [SIZE-1:0] product
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SIZE);

  logic [SIZE-1:0] mcand;
  logic [SIZE-1:0] mplier;
  logic [SIZE-1:0] acc;
  logic [CW-1:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= CNT_INIT;
    end else if (count != '0) begin
      // Bits shifted past the top of mcand only feed the discarded high half.
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

  assign done    = (count == CW'(1));
  assign product = acc;

endmodule

// File: rtl/ex_stage_hs.sv
// MIPS execute stage with valid/ready on both sides; single-cycle ALU ops plus an
// iterative multiply that holds off ID while busy. Result register holds under backpressure.
module ex_stage_hs
  import ex_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int CTRL_W = 11,
  parameter int SH_W   = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   readData1,
  input  logic [SIZE-1:0]   readData2,
  input  logic [SH_W-1:0]   shamt,
  input  logic [SH_W-1:0]   writeReg,
  input  logic [CTRL_W-1:0] control,
  input  logic [SIZE-1:0]   PC_4_ID,
  input  logic [3:0]        ALUcontrol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE-1:0]   ALUresult,
  output logic [SH_W-1:0]   writeReg_EX,
  output logic [SIZE-1:0]   PC_4_EX,
  output logic [CTRL_W-1:0] control_EX,
  output logic              busy
);

  ex_state_t state, state_nxt;

  logic              slot_free;
  logic              accept;
  logic              is_mul;
  logic              mul_start;
  logic              load_alu;
  logic              load_mul;
  logic              mul_done;
  logic [SIZE-1:0]   mul_product;
  logic [SIZE-1:0]   alu_res;

  // Sideband captured at multiply accept, released with the product.
  logic [SH_W-1:0]   hold_wr;
  logic [CTRL_W-1:0] hold_ctrl;
  logic [SIZE-1:0]   hold_pc;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_mul    = (ALUcontrol == ALU_MUL);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)         state_nxt = ST_DONE;
      ST_DONE: if (slot_free)        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && slot_free && !rst;
    busy      = (state != ST_IDLE);
    mul_start = accept && is_mul;
    load_alu  = accept && !is_mul;
    load_mul  = (state == ST_DONE) && slot_free;
  end

  always_comb begin
    alu_res = '0;
    case (ALUcontrol)
      ALU_ADD:  alu_res = readData1 + readData2;
      ALU_SUB:  alu_res = readData1 - readData2;
      ALU_AND:  alu_res = readData1 & readData2;
      ALU_OR:   alu_res = readData1 | readData2;
      ALU_NOR:  alu_res = ~(readData1 | readData2);
      ALU_XOR:  alu_res = readData1 ^ readData2;
      ALU_SLT:  alu_res[0] = ($signed(readData1) < $signed(readData2));
      ALU_SLTU: alu_res[0] = (readData1 < readData2);
      ALU_SLL:  alu_res = readData2 << shamt;
      ALU_SRL:  alu_res = readData2 >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(readData2) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  ex_mul_iter #(.SIZE(SIZE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (readData1),
    .b       (readData2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_wr   <= '0;
      hold_ctrl <= '0;
      hold_pc   <= '0;
    end else if (mul_start) begin
      hold_wr   <= writeReg;
      hold_ctrl <= control;
      hold_pc   <= PC_4_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      ALUresult   <= '0;
      writeReg_EX <= '0;
      PC_4_EX     <= '0;
      control_EX  <= '0;
    end else begin
      if (load_alu) begin
        ALUresult   <= alu_res;
        writeReg_EX <= writeReg;
        PC_4_EX     <= PC_4_ID;
        control_EX  <= control;
      end else if (load_mul) begin
        ALUresult   <= mul_product;
        writeReg_EX <= hold_wr;
        PC_4_EX     <= hold_pc;
        control_EX  <= hold_ctrl;
      end
      // A drain in the same cycle as a load leaves out_valid set.
      if (load_alu || load_mul) out_valid <= 1'b1;
      else if (out_ready)       out_valid <= 1'b0;
    end
  end

endmodule
